// File: rtl/bit_serial_alu_seq_if.sv
// Handshake/bus bundle for the bit-serial ALU.
//   start/op/a/b                      : request from the controller (master drives)
//   busy/done/result/cout/zero/overflow : status and result from the engine (slave drives)
interface bit_serial_alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zero, overflow
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU engine: processes one operand bit per cycle, LSB first, through an internal
// 1-bit ALU slice with a registered carry, and returns a WIDTH-bit result with start/done.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : slave side of bit_serial_alu_seq_if (start/op/a/b in; busy/done/result/cout/
//           zero/overflow out)
// AluOp: 000 ADD, 010 SUB, 011 AND, 111 OR, 101 NOR, 100 XOR; others yield a zero result.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  bit_serial_alu_seq_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b111;
  localparam logic [2:0] OpNor = 3'b101;
  localparam logic [2:0] OpXor = 3'b100;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, done_q, done_d;
  logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

  logic             is_arith, is_logic, a_bit, b_bit, r_bit, carry_nxt;
  logic [WIDTH-1:0] shift_nxt;

  // 1-bit slice on the current LSBs of the latched operands.
  always_comb begin
    is_arith  = (op_q == OpAdd) || (op_q == OpSub);
    is_logic  = 1'b1;
    a_bit     = a_q[0];
    b_bit     = b_q[0] ^ (op_q == OpSub);  // SUB inverts B; the +1 comes from the initial carry
    carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    unique case (op_q)
      OpAdd, OpSub: r_bit = a_bit ^ b_bit ^ carry_q;
      OpAnd:        r_bit = a_bit & b_bit;
      OpOr:         r_bit = a_bit | b_bit;
      OpNor:        r_bit = ~(a_bit | b_bit);
      OpXor:        r_bit = a_bit ^ b_bit;
      default: begin
        r_bit    = 1'b0;
        is_logic = 1'b0;
      end
    endcase
    shift_nxt = {r_bit, sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = (bus.op == OpSub);
          cnt_d   = '0;
          sr_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sr_d  = shift_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (is_arith) carry_d = carry_nxt;
        if (cnt_q == LastCnt) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          result_d = is_logic ? shift_nxt : '0;
          cout_d   = is_arith & carry_nxt;
          // carry_q is the carry into the MSB on this last bit
          ovf_d    = is_arith & (carry_q ^ carry_nxt);
          zero_d   = ~is_logic | (shift_nxt == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
module tb_bit_serial_alu_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_serial_alu_seq_if #(.WIDTH(W)) bus ();

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic last_done = 1'b0;

  task automatic add(input string name, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] res, input logic c,
                     input logic z, input logic v);
    vec_t e;
    e.name = name; e.op = op; e.a = a; e.b = b;
    e.res = res; e.cout = c; e.zero = z; e.ovf = v;
    tbl.push_back(e);
  endtask

  // Arithmetic reference (word-level, not bit-serial).
  function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    vec_t       e;
    logic [W:0] s;
    e.name = "rand"; e.op = op; e.a = a; e.b = b;
    e.res = '0; e.cout = 1'b0; e.ovf = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0]; e.cout = s[W];
        e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b010: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        e.res = s[W-1:0]; e.cout = s[W];
        e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b011:  e.res = a & b;
      3'b111:  e.res = a | b;
      3'b101:  e.res = ~(a | b);
      3'b100:  e.res = a ^ b;
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic on_done();
    vec_t e;
    n_vec++;
    n_done++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL spurious_done: done pulse with no operation outstanding (result=%0h)",
               bus.result);
      return;
    end
    e = sb.pop_front();
    if (bus.result !== e.res || bus.cout !== e.cout || bus.zero !== e.zero ||
        bus.overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL %s op=%b a=%0h b=%0h: got res=%0h c=%b z=%b v=%b, want res=%0h c=%b z=%b v=%b",
               e.name, e.op, e.a, e.b, bus.result, bus.cout, bus.zero, bus.overflow,
               e.res, e.cout, e.zero, e.ovf);
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    last_done = bus.done;
    if (bus.done) on_done();
  endtask

  task automatic issue(input vec_t e, input bit push);
    int g = 0;
    while (bus.busy && g < 4 * W) begin
      tick();
      g++;
    end
    if (bus.busy) begin
      n_vec++; n_fail++;
      $display("FAIL issue_timeout: busy=%b, want 0", bus.busy);
    end
    bus.start = 1'b1; bus.op = e.op; bus.a = e.a; bus.b = e.b;
    if (push) sb.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || bus.busy) && g < 4 * W * 8) begin
      tick();
      g++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL done_timeout: %0d results outstanding, want 0", sb.size());
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_busy"}, W'(bus.busy), '0);
    chk({name, "_done"}, W'(bus.done), '0);
    chk({name, "_result"}, bus.result, '0);
    chk({name, "_flags"}, W'({bus.cout, bus.zero, bus.overflow}), '0);
  endtask

  initial begin
    vec_t        e;
    int          cnt;
    int          d0;
    logic [2:0]  ops [8];
    ops = '{3'b000, 3'b010, 3'b011, 3'b111, 3'b101, 3'b100, 3'b001, 3'b110};

    add("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    add("sub_05_05", 3'b010, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    add("sub_00_01", 3'b010, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    add("and",       3'b011, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
    add("or",        3'b111, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
    add("nor",       3'b101, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
    add("xor",       3'b100, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
    add("op001",     3'b001, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
    add("op110",     3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0);
    add("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    add("sub_80_01", 3'b010, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);
    add("add_80_80", 3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_state("reset");

    // Table vectors, each run to completion.
    foreach (tbl[i]) begin
      issue(tbl[i], 1'b1);
      wait_idle();
    end

    // Random vectors issued back-to-back.
    for (int i = 0; i < 16; i++) begin
      e = model(ops[$urandom_range(0, 7)], W'($urandom), W'($urandom));
      issue(e, 1'b1);
    end
    wait_idle();

    // Start/operand changes while busy are ignored.
    e = model(3'b000, 8'h01, 8'h01);
    e.name = "busy_ignore";
    issue(e, 1'b1);
    tick();
    bus.start = 1'b1; bus.op = 3'b111; bus.a = 8'hFF; bus.b = 8'hFF;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    while (!last_done && cnt < 4 * W) begin
      tick();
      cnt++;
    end
    // Re-issue in the done cycle: accepted on the next edge, done lands W edges after that.
    e = model(3'b000, 8'h03, 8'h04);
    e.name = "b2b";
    d0 = n_done;
    issue(e, 1'b1);
    chk("done_one_cycle", W'(bus.done), '0);
    cnt = 1;
    while (n_done == d0 && cnt < 4 * W) begin
      tick();
      cnt++;
    end
    chk("b2b_latency", W'(cnt), W'(W + 1));

    // Reset mid-operation aborts with no done.
    e = model(3'b000, 8'hFF, 8'h01);
    issue(e, 1'b0);
    tick(); tick();
    chk("result_held", bus.result, 8'h07);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("abort");
    d0 = n_done;
    repeat (2 * W) tick();
    chk("abort_no_done", W'(n_done - d0), '0);
    e = model(3'b010, 8'h10, 8'h03);
    e.name = "after_abort";
    issue(e, 1'b1);
    wait_idle();

    // Reset and start in the same cycle: start is dropped.
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'b000; bus.a = 8'h01; bus.b = 8'h01;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    chk("reset_wins_busy", W'(bus.busy), '0);
    d0 = n_done;
    repeat (2 * W) tick();
    chk("reset_wins_no_done", W'(n_done - d0), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
